// File: rtl/prbs15_byte_gen.sv
// rtl/prbs15_byte_gen.sv - PRBS-15 (x^15+x^14+1) byte burst generator
// triggered by the rising edge of pattern_valid.
module prbs15_byte_gen #(
  parameter logic [14:0] DEF_SEED = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pattern_valid,
  input  logic [14:0] seed,
  input  logic [7:0]  num_bytes,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  byte_c;
  logic        pv_q;
  logic        valid_q, busy_q, done_q;
  logic        trigger, xfer;

  assign trigger = pattern_valid & ~pv_q;
  assign xfer    = valid_q & out_ready;

  // Eight LFSR steps per byte; the first feedback bit lands in the MSB.
  always_comb begin : step8
    logic [14:0] s;
    logic        fb;
    s      = lfsr_q;
    fb     = 1'b0;
    byte_c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb            = s[14] ^ s[13];
      s             = {s[13:0], fb};
      byte_c[7 - i] = fb;
    end
    lfsr_adv = s;
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          lfsr_d  = (seed == 15'd0) ? DEF_SEED : seed;
          cnt_d   = num_bytes;
          state_d = (num_bytes != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (xfer) begin
          lfsr_d = lfsr_adv;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (!pattern_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= 15'h0;
      cnt_q   <= 8'h0;
      pv_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pv_q    <= pattern_valid;
      valid_q <= (state_d == RUN);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign out_byte  = valid_q ? byte_c : 8'h00;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prbs15_byte_gen.sv
// tb/tb_prbs15_byte_gen.sv - self-checking bench for prbs15_byte_gen
module tb_prbs15_byte_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pattern_valid;
  logic [14:0] seed;
  logic [7:0]  num_bytes;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  prbs15_byte_gen dut (
    .clk           (clk),
    .rst           (rst),
    .pattern_valid (pattern_valid),
    .seed          (seed),
    .num_bytes     (num_bytes),
    .out_byte      (out_byte),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    logic [14:0] seed;
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit stream recurrence b[n] = b[n-15] ^ b[n-14], seeded oldest-bit first.
  task automatic build_model(input logic [14:0] sd, input int n);
    bit          hist[$];
    bit          nb;
    logic [14:0] s;
    logic [7:0]  b;
    exp_q.delete();
    s = (sd == 15'd0) ? 15'h7FFF : sd;
    for (int i = 14; i >= 0; i--) hist.push_back(s[i]);
    for (int k = 0; k < n; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        nb = hist[hist.size() - 15] ^ hist[hist.size() - 14];
        hist.push_back(nb);
        b = {b[6:0], nb};
      end
      exp_q.push_back(b);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready from rpat bits.
  task automatic run_burst(input logic [14:0] sd, input int n, input int mode, input logic [31:0] rpat);
    int         got;
    int         cyc;
    logic [7:0] held;
    logic       stalled;
    build_model(sd, n);
    got_q.delete();
    seed          = sd;
    num_bytes     = n[7:0];
    pattern_valid = 1'b1;
    out_ready     = 1'b0;
    check("pre_trigger_valid", 32'(out_valid), 32'd0);
    tick();
    seed      = 15'($urandom);
    num_bytes = 8'($urandom);
    check("latency_valid", 32'(out_valid), 32'(n != 0));
    check("latency_busy", 32'(busy), 32'(n != 0));
    check("latency_done", 32'(done), 32'(n == 0));
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = 8'h00;
    while (got < n && cyc < 1000) begin
      if (!out_valid) begin
        check("valid_during_burst", 32'(out_valid), 32'd1);
        break;
      end
      if (stalled) check("stall_hold", 32'(out_byte), 32'(held));
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc < 32) ? rpat[cyc] : 1'b1;
      endcase
      if (out_ready) begin
        check("byte", 32'(out_byte), 32'(exp_q[got]));
        got_q.push_back(out_byte);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_byte;
      end
      tick();
      cyc++;
    end
    check("transfers", 32'(got), 32'(n));
    out_ready = 1'($urandom_range(0, 1));
    check("end_valid", 32'(out_valid), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic release_pv();
    pattern_valid = 1'b0;
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    pattern_valid = 1'b0;
    out_ready     = 1'b0;
    seed          = 15'h0;
    num_bytes     = 8'h0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_byte", 32'(out_byte), 32'd0);
    rst = 1'b1;
    tick();

    vecs[0] = '{15'h7FFF, 2, 8'h00, 8'h02};
    vecs[1] = '{15'h0000, 1, 8'h00, 8'h00};
    vecs[2] = '{15'h0001, 2, 8'h00, 8'h06};
    for (int i = 0; i < 3; i++) begin
      run_burst(vecs[i].seed, vecs[i].n, 0, 32'd0);
      if (got_q.size() >= 1) check("tbl_b0", 32'(got_q[0]), 32'(vecs[i].b0));
      if (got_q.size() >= 2) check("tbl_b1", 32'(got_q[1]), 32'(vecs[i].b1));
      release_pv();
    end

    // Ready pattern 1,0,0,1,1 over a three-byte burst.
    run_burst(15'h7FFF, 3, 2, 32'h19);
    if (got_q.size() >= 3) check("stall_b2", 32'(got_q[2]), 32'h00);
    release_pv();

    run_burst(15'h1234, 0, 0, 32'd0);
    release_pv();

    // Held pattern_valid must not retrigger; a fresh rise resamples the seed.
    run_burst(15'h7FFF, 2, 0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      seed = 15'h0001;
      tick();
      check("hold_done", 32'(done), 32'd1);
      check("hold_valid", 32'(out_valid), 32'd0);
    end
    release_pv();
    run_burst(15'h0001, 2, 0, 32'd0);
    if (got_q.size() >= 2) check("rearm_b1", 32'(got_q[1]), 32'h06);
    release_pv();

    // Reset after one of four bytes.
    seed          = 15'h7FFF;
    num_bytes     = 8'd4;
    pattern_valid = 1'b1;
    out_ready     = 1'b1;
    tick();
    check("mid_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_byte", 32'(out_byte), 32'd0);
    pattern_valid = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
    end
    run_burst(15'h4A5C, 4, 0, 32'd0);
    release_pv();

    for (int i = 0; i < 25; i++) begin
      run_burst(15'($urandom), int'($urandom_range(0, 12)), 1, 32'd0);
      release_pv();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs15_byte_gen.md
Name: prbs15_byte_gen

Overview:
- Downstream stage of the PRBS-15 pattern-check FSM.
- It starts when the FSM reports success: a rising edge on pattern_valid.
- It then emits num_bytes bytes of the PRBS-15 sequence (x^15 + x^14 + 1) from a seed, over a valid/ready byte interface.
- It flags completion and re-arms only after pattern_valid drops.

Parameters:
- DEF_SEED, 15'h7FFF, substitute seed used when the sampled seed is all-zero (lock-up avoidance).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- pattern_valid  input  1  success level from the checker FSM; only its rising edge triggers generation.
- seed  input  15  LFSR seed, sampled on the trigger cycle.
- num_bytes  input  8  byte count, sampled on the trigger cycle; 0..255.
- out_byte  output  8  current PRBS byte; MSB is the first-generated bit.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  sink accepts out_byte.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst low, async): state=IDLE, lfsr=15'h0, cnt=0, pv_d=0, out_valid=0, busy=0, done=0, out_byte=0.
- Trigger = pattern_valid & ~pv_d. pv_d is pattern_valid registered every cycle.
- State IDLE:
  - On trigger: lfsr <= (seed==0 ? DEF_SEED : seed); cnt <= num_bytes.
  - Next state is RUN if num_bytes!=0, else DONE.
- State RUN:
  - busy=1; out_valid=1.
  - out_byte is combinational from lfsr: 8 successive steps.
  - One step: fb = s[14]^s[13]; s <= {s[13:0], fb}; output bit = fb.
  - The bit from step 0 goes to out_byte[7] and the bit from step 7 to out_byte[0].
  - Transfer = out_valid & out_ready.
  - On transfer: lfsr advances 8 steps; cnt decrements.
  - If cnt==1 at the transfer, go to DONE.
  - Without out_ready, out_byte and out_valid stay stable.
  - Back-to-back transfers are allowed, one byte per cycle at 100% throughput.
  - pattern_valid changes during RUN are ignored.
- State DONE:
  - done=1, out_valid=0, busy=0.
  - When pattern_valid==0, go to IDLE.
  - A new trigger needs pattern_valid to fall and then rise again.
  - A checker held in SUCCESS therefore produces exactly one burst.
- Latency: trigger at clock edge N → out_valid high from edge N+1.
- Simultaneous events: a trigger in IDLE takes priority over nothing else. A trigger seen in RUN or DONE is ignored; pv_d still updates.
- The state encoding is 2 bits; the FSM is registered with a combinational next-state block.
- Reset mid-burst: everything returns to reset values; the partial burst is dropped and no done pulse is produced.

Test Plan:
- Seed 15'h7FFF, num_bytes=2, out_ready=1, raise pattern_valid → out_valid high one cycle later; bytes 8'h00 then 8'h02; then done=1 and out_valid=0.
- Seed 15'h0000, num_bytes=1 → same first byte as seed 15'h7FFF (8'h00); proves the DEF_SEED substitution.
- Seed 15'h7FFF, num_bytes=3, out_ready toggles 1,0,0,1,1 → out_byte holds stable while stalled; exactly 3 transfers; sequence 8'h00, 8'h02, then the third step-group byte.
- num_bytes=0, trigger → out_valid never asserts; done=1 one cycle after the trigger.
- pattern_valid held high after DONE, then pulsed low and high again → no second burst while held; a new burst starts only after the re-rise, with the seed resampled.
- rst asserted low during RUN after 1 of 4 bytes → all outputs 0 immediately; after release, state is IDLE and out_valid stays 0 until the next trigger.
